// File: rtl/button_conditioner.sv
// button_conditioner: per-channel 2-flop sync, debounce, press/release pulses and auto-repeat.
// Repeat is decoded from FSM state/count so a release in the same cycle can veto it.
module button_conditioner #(
  parameter int          N_BTN          = 5,
  parameter logic [31:0] DEBOUNCE_TICKS = 32'd1_000_000,
  parameter logic [31:0] HOLD_TICKS     = 32'd50_000_000,
  parameter logic [31:0] REPEAT_TICKS   = 32'd10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;
  logic [N_BTN-1:0] s1, sync;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= btn_in;
      sync <= s1;
    end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [31:0] dcnt, rcnt, rcnt_n;
    logic        lvl, prs, rls, acc, rep;
    state_t      st, st_n;
    assign acc = sync[i] != lvl && dcnt == DEBOUNCE_TICKS - 32'd1;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        dcnt <= '0;
        lvl  <= 1'b0;
        prs  <= 1'b0;
        rls  <= 1'b0;
        st   <= S_IDLE;
        rcnt <= '0;
      end else begin
        dcnt <= (sync[i] == lvl || acc) ? '0 : dcnt + 32'd1;
        lvl  <= acc ? sync[i] : lvl;
        prs  <= acc && sync[i];
        rls  <= acc && !sync[i];
        st   <= st_n;
        rcnt <= rcnt_n;
      end
    always_comb begin
      st_n   = st;
      rcnt_n = '0;
      rep    = 1'b0;
      if (HOLD_TICKS != 32'd0)
        case (st)
          S_IDLE: st_n = prs ? S_HOLD : S_IDLE;
          S_HOLD: begin
            rep    = rcnt == HOLD_TICKS - 32'd1;
            st_n   = rep ? S_REPEAT : S_HOLD;
            rcnt_n = rep ? '0 : rcnt + 32'd1;
          end
          S_REPEAT: begin
            rep    = rcnt == REPEAT_TICKS - 32'd1;
            rcnt_n = rep ? '0 : rcnt + 32'd1;
          end
          default: st_n = S_IDLE;
        endcase
      if (rls) begin
        st_n   = S_IDLE;
        rcnt_n = '0;
        rep    = 1'b0;
      end
    end
    assign btn_level[i]   = lvl;
    assign btn_press[i]   = prs;
    assign btn_release[i] = rls;
    assign btn_repeat[i]  = rep;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: model-checked bench with a repeat-enabled and a repeat-disabled instance.
module tb_button_conditioner;
  localparam int N = 5, DT = 4, HT = 20, RT = 5;
  logic clk = 0, rst = 1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] lvl, prs, rls, rep, lvl0, prs0, rls0, rep0;
  int n_chk = 0, n_fail = 0, cyc = 0, p;
  logic [N-1:0] m_lvl = '0, m_prs = '0, m_rls = '0, m_rep = '0;
  logic [N-1:0] hist[$];
  int  age[N];
  bit  held[N];

  button_conditioner #(.N_BTN(N), .DEBOUNCE_TICKS(DT), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl), .btn_press(prs),
    .btn_release(rls), .btn_repeat(rep));
  button_conditioner #(.N_BTN(N), .DEBOUNCE_TICKS(DT), .HOLD_TICKS(0), .REPEAT_TICKS(RT)) dut0 (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl0), .btn_press(prs0),
    .btn_release(rls0), .btn_repeat(rep0));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, a, e, $time);
    end
  endtask

  // Reference: a new level is accepted once the last DT synchronized samples all
  // disagree with it; repeats follow from the age of the current press.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hist.delete();
      m_lvl = '0; m_prs = '0; m_rls = '0; m_rep = '0;
      for (int i = 0; i < N; i++) begin held[i] = 0; age[i] = 0; end
    end else begin
      cyc++;
      hist.push_front(btn_in);
      if (hist.size() > DT + 2) void'(hist.pop_back());
      m_prs = '0; m_rls = '0; m_rep = '0;
      for (int i = 0; i < N; i++) begin
        bit ch;
        ch = hist.size() == DT + 2;
        for (int j = 2; j < DT + 2; j++) if (ch && hist[j][i] == m_lvl[i]) ch = 0;
        if (ch) begin
          m_lvl[i] = ~m_lvl[i];
          if (m_lvl[i]) begin m_prs[i] = 1; held[i] = 1; age[i] = 0; end
          else begin m_rls[i] = 1; held[i] = 0; end
        end else if (held[i]) begin
          age[i]++;
          m_rep[i] = age[i] == HT || (age[i] > HT && (age[i] - HT) % RT == 0);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("level", lvl, m_lvl);
    chk("press", prs, m_prs);
    chk("release", rls, m_rls);
    chk("repeat", rep, m_rep);
    chk("level_h0", lvl0, m_lvl);
    chk("press_h0", prs0, m_prs);
    chk("release_h0", rls0, m_rls);
    chk("repeat_h0", rep0, '0);
  end

  task automatic wait_press(input int b, output int pc);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (prs[b]) break;
    end
    chk("press_seen", prs[b], 1);
    pc = cyc;
  endtask

  typedef struct {logic [N-1:0] in; int cycles; logic [N-1:0] lvl;} vec_t;
  vec_t tbl[7];

  initial begin
    tbl[0] = '{5'h00, 8, 5'h00};
    tbl[1] = '{5'h1F, 8, 5'h1F};
    tbl[2] = '{5'h05, 8, 5'h05};
    tbl[3] = '{5'h0A, 3, 5'h05};
    tbl[4] = '{5'h05, 8, 5'h05};
    tbl[5] = '{5'h12, 8, 5'h12};
    tbl[6] = '{5'h13, 2, 5'h12};
    repeat (3) @(negedge clk);
    #2 chk("reset_level", lvl, 0);
    chk("reset_press", prs, 0);
    chk("reset_repeat", rep, 0);
    @(negedge clk) rst = 0;
    repeat (3) @(negedge clk);
    // clean press and release
    btn_in[0] = 1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("t1_level", lvl[0], k >= 5);
      chk("t1_press", prs, k == 5 ? 5'h01 : 5'h00);
    end
    repeat (30) @(negedge clk);
    btn_in[0] = 0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("t1_rlevel", lvl[0], k < 5);
      chk("t1_release", rls, k == 5 ? 5'h01 : 5'h00);
    end
    // bounce
    @(negedge clk);
    for (int r = 0; r < 5; r++) begin
      btn_in[1] = 1;
      repeat (3) begin @(negedge clk); chk("t2_quiet", prs[1] | rls[1], 0); end
      btn_in[1] = 0;
      @(negedge clk); chk("t2_quiet", prs[1] | rls[1], 0);
    end
    btn_in[1] = 1;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("t2_press", prs[1], k == 5);
    end
    @(negedge clk) btn_in[1] = 0;
    repeat (12) @(negedge clk);
    // auto-repeat
    btn_in[2] = 1;
    wait_press(2, p);
    for (int d = 1; d <= 60; d++) begin
      @(posedge clk); #1;
      chk("t3_repeat", rep[2], d == HT || (d > HT && (d - HT) % RT == 0));
    end
    btn_in[2] = 0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 20; k++) begin @(negedge clk); chk("t3_after", rep[2], 0); end
    // release colliding with a repeat terminal count
    btn_in[2] = 1;
    wait_press(2, p);
    repeat (19) @(posedge clk);
    #1 btn_in[2] = 0;
    repeat (6) @(posedge clk);
    #1 chk("t4_release", rls, 5'h04);
    chk("t4_repeat", rep[2], 0);
    chk("t4_cyc", cyc - p, 25);
    for (int k = 0; k < 10; k++) begin @(negedge clk); chk("t4_after", rep[2], 0); end
    // async reset mid-hold
    btn_in[3] = 1;
    wait_press(3, p);
    repeat (25) @(negedge clk);
    #2 rst = 1;
    #1 chk("t5_level", lvl, 0);
    chk("t5_press", prs, 0);
    chk("t5_release", rls, 0);
    chk("t5_repeat", rep, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("t5_repress", prs, k == 5 ? 5'h08 : 5'h00);
      chk("t5_norel", rls, 0);
    end
    @(negedge clk) btn_in = '0;
    repeat (10) @(negedge clk);
    // simultaneous press, repeat-disabled instance must stay quiet
    btn_in = 5'h1F;
    for (int k = 0; k <= 6; k++) begin
      @(posedge clk); #1;
      chk("t6_press", prs, k == 5 ? 5'h1F : 5'h00);
    end
    for (int k = 0; k < 100; k++) begin @(negedge clk); chk("t6_rep0", rep0, 0); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk) btn_in = tbl[i].in;
      repeat (tbl[i].cycles) @(negedge clk);
      chk("tbl_level", lvl, tbl[i].lvl);
      chk("tbl_level_h0", lvl0, tbl[i].lvl);
    end
    // randomized traffic, checked continuously against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) btn_in[$urandom_range(0, N - 1)] ^= 1'b1;
    end
    btn_in = '0;
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-side companion to the board LED drivers. It conditions the ZedBoard pushbuttons into clean per-button signals for the fabric:
- a 2-flop synchronizer and a per-channel debounce counter;
- a debounced level and one-cycle press/release pulses;
- an auto-repeat pulse train while a button is held.

It sits between the raw package pins and any control logic that steps or selects display patterns.

## Interface
- N_BTN, 5, number of independent button channels (1..32)
- DEBOUNCE_TICKS, 32'd1_000_000, consecutive stable clk cycles required to accept a new level (>= 1)
- HOLD_TICKS, 32'd50_000_000, cycles from press pulse to first repeat pulse; 0 disables auto-repeat
- REPEAT_TICKS, 32'd10_000_000, cycles between subsequent repeat pulses (>= 1)

Ports:
- clk  input  1  system clock; all state on its rising edge
- rst  input  1  asynchronous, active-high reset
- btn_in  input  N_BTN  raw, asynchronous button inputs, 1 = pressed
- btn_level  output  N_BTN  debounced level per channel
- btn_press  output  N_BTN  one-cycle pulse on debounced 0->1
- btn_release  output  N_BTN  one-cycle pulse on debounced 1->0
- btn_repeat  output  N_BTN  one-cycle auto-repeat pulse while held

## Operation
- Reset: all outputs are 0 immediately on rst assertion, with no clock required. Synchronizer flops, debounce counters, hold counters and FSMs are cleared.
- Synchronizer: two flops per channel, reset to 0. sync = btn_in delayed by 2 edges. No logic is placed between the two flops.
- Debounce, per channel, 32-bit counter dcnt:
  - sync == btn_level: dcnt <= 0.
  - sync != btn_level and dcnt == DEBOUNCE_TICKS-1: btn_level <= sync, dcnt <= 0.
  - Otherwise: dcnt <= dcnt + 1.
  - Any return of sync to the current level restarts the count.
- Edge pulses are registered and asserted in the same cycle btn_level first shows its new value; they are high for exactly one cycle.
- Auto-repeat FSM per channel, 32-bit counter rcnt. States:
  - S_IDLE: rcnt = 0. On btn_press -> S_HOLD, rcnt <= 0.
  - S_HOLD: rcnt++. At rcnt == HOLD_TICKS-1: assert btn_repeat, rcnt <= 0, go to S_REPEAT.
  - S_REPEAT: rcnt++. At rcnt == REPEAT_TICKS-1: assert btn_repeat, rcnt <= 0.
  - btn_release in any state -> S_IDLE, rcnt <= 0. No btn_repeat in the release cycle or after it.
  - HOLD_TICKS == 0: the FSM stays in S_IDLE and btn_repeat is constant 0.
- Channels are fully independent. Any combination of bits may pulse in the same cycle.
- Counters never wrap: each is cleared at its terminal count or on a level match.

## Timing
- Latency:
  - Edge 0 is the first rising edge sampling btn_in at its new value.
  - btn_level changes, and btn_press/btn_release pulse, after edge DEBOUNCE_TICKS+1, provided btn_in is stable through that edge.
  - Total latency is DEBOUNCE_TICKS+2 edges.
- With press pulse in cycle P, btn_repeat is high in cycles P+HOLD_TICKS and P+HOLD_TICKS+k*REPEAT_TICKS (k >= 1), until release.
- Glitches shorter than DEBOUNCE_TICKS cycles at sync never change btn_level and produce no pulses.
- Reset mid-operation:
  - All outputs drop asynchronously.
  - After rst deasserts, a button still held is treated as a new press: btn_press fires DEBOUNCE_TICKS+2 edges after the first edge with rst low.
  - No btn_release is generated by reset.
- A repeat terminal count coinciding with the release cycle: release wins and no btn_repeat is asserted.

## Test plan
Use N_BTN=5, DEBOUNCE_TICKS=4, HOLD_TICKS=20, REPEAT_TICKS=5 unless noted.

1. Clean press: btn_in[0] rises before edge 0 and is held 30 cycles -> btn_level[0] rises after edge 5; btn_press = 5'h01 for exactly one cycle. Drop btn_in[0] -> btn_release = 5'h01 one cycle, 6 edges after the drop.
2. Bounce: btn_in[1] toggles high 3 cycles / low 1 cycle, 5 times, then stays high -> no pulses during toggling; exactly one btn_press[1], 6 edges after the final rise.
3. Auto-repeat: btn_in[2] held 60 cycles, press pulse at cycle P -> btn_repeat[2] high at exactly P+20, P+25, P+30 … up to release; none after btn_release[2].
4. Release collides with repeat terminal: release timed so btn_release[2] lands at P+25 -> btn_repeat[2] stays 0 that cycle; the FSM returns to S_IDLE.
5. Async reset mid-hold: assert rst between clock edges while btn_in[3] is held in S_REPEAT -> all outputs 0 before the next edge. Deassert rst with the button still held -> btn_press[3] fires 6 edges after the first edge with rst low, with no btn_release.
6. Simultaneous inputs: all five btn_in rise on the same cycle -> btn_press = 5'h1F for one cycle. Then with HOLD_TICKS=0, hold 100 cycles -> btn_repeat stays 5'h00.
